// File: rtl/led_drv_pkg.sv
// Shared types and helpers for the LED PWM output stage: FSM state enum,
// 2-bit brightness code constants and the code-to-duty mapping.
package led_drv_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    CHASE = 1'b1
  } led_state_e;

  localparam logic [1:0] CODE_OFF  = 2'd0;
  localparam logic [1:0] CODE_Q    = 2'd1;
  localparam logic [1:0] CODE_H    = 2'd2;
  localparam logic [1:0] CODE_FULL = 2'd3;

  // Number of "on" counts per frame; CODE_FULL returns a whole frame, but
  // the top forces that code on regardless of the compare.
  function automatic logic [31:0] duty_of(input logic [1:0] code,
                                          input int unsigned pwm_bits);
    logic [31:0] d;
    case (code)
      CODE_OFF:  d = '0;
      CODE_Q:    d = 32'd1 << (pwm_bits - 2);
      CODE_H:    d = 32'd1 << (pwm_bits - 1);
      CODE_FULL: d = 32'd1 << pwm_bits;
      default:   d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/led_pwm_counter.sv
// Free-running PWM frame counter with enable, shadow-load strobe and
// registered frame-start pulse.
module led_pwm_counter #(
  parameter int PWM_BITS = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  output logic [PWM_BITS-1:0] o_count,
  output logic                o_load,
  output logic                o_live,
  output logic                o_frame
);

  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  logic [PWM_BITS-1:0] r_count;
  logic                r_active;
  logic                r_frame;

  // The first enabled cycle is a start cycle: counter stays at 0 while the
  // codes are sampled, exactly like the cycle that wraps from CNT_MAX.
  assign o_live  = i_en & r_active;
  assign o_load  = i_en & (~r_active | (r_count == CNT_MAX));
  assign o_count = r_count;
  assign o_frame = r_frame;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count  <= '0;
      r_active <= 1'b0;
      r_frame  <= 1'b0;
    end else begin
      r_active <= i_en;
      r_frame  <= o_live & (r_count == '0);
      if (o_live) r_count <= r_count + PWM_BITS'(1);
      else        r_count <= '0;
    end
  end

endmodule

// File: rtl/led_pwm_driver.sv
// Board LED stage: 4 x 2-bit brightness codes -> frame-synchronous PWM pins.
// Optional power-on LED chase when LED_SELFTEST_EN is defined.
module led_pwm_driver
  import led_drv_pkg::*;
#(
  parameter int PWM_BITS      = 8,
  parameter int NUM_LEDS      = 4,
  parameter int SELFTEST_STEP = 1048576
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [2*NUM_LEDS-1:0] in_leds,
  input  logic                  in_run,
  output logic [NUM_LEDS-1:0]   out_leds,
  output logic                  out_frame,
  output logic                  out_busy,
  output led_state_e            o_dbg_state
);

  led_state_e            w_state;
  logic                  w_en;
  logic                  w_load;
  logic                  w_live;
  logic [PWM_BITS-1:0]   w_count;
  logic [NUM_LEDS-1:0]   w_pwm;
  logic [NUM_LEDS-1:0]   w_chase_leds;
  logic [2*NUM_LEDS-1:0] r_shadow;
  logic [NUM_LEDS-1:0]   r_leds;

`ifdef LED_SELFTEST_EN
  localparam int IDX_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int STEP_W = (SELFTEST_STEP > 1) ? $clog2(SELFTEST_STEP) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_LEDS - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SELFTEST_STEP - 1);

  led_state_e        r_state;
  led_state_e        w_state_nxt;
  logic [STEP_W-1:0] r_step;
  logic [IDX_W-1:0]  r_idx;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= CHASE;
      r_step  <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == CHASE) begin
        if (r_step == STEP_LAST) begin
          r_step <= '0;
          r_idx  <= r_idx + IDX_W'(1);
        end else begin
          r_step <= r_step + STEP_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_chase_leds = '0;
    if (r_state == CHASE) begin
      w_chase_leds[r_idx] = 1'b1;
      if ((r_step == STEP_LAST) && (r_idx == IDX_LAST)) w_state_nxt = RUN;
    end
  end

  assign w_state  = r_state;
  assign out_busy = (r_state == CHASE);
`else
  logic w_unused_step;
  assign w_unused_step = (SELFTEST_STEP > 0);
  assign w_state       = RUN;
  assign w_chase_leds  = '0;
  assign out_busy      = 1'b0;
`endif

  assign w_en = in_run & (w_state == RUN);

  led_pwm_counter #(
    .PWM_BITS (PWM_BITS)
  ) u_counter (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_en    (w_en),
    .o_count (w_count),
    .o_load  (w_load),
    .o_live  (w_live),
    .o_frame (out_frame)
  );

  always_comb begin
    w_pwm = '0;
    for (int k = 0; k < NUM_LEDS; k++) begin
      w_pwm[k] = (r_shadow[2*k +: 2] == CODE_FULL) ||
                 (32'(w_count) < duty_of(r_shadow[2*k +: 2], PWM_BITS));
    end
  end

  // Shadows change only at frame starts, so a frame never mixes two codes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shadow <= '0;
      r_leds   <= '0;
    end else begin
      if (w_load) r_shadow <= in_leds;
      if (w_state == CHASE) r_leds <= w_chase_leds;
      else if (w_live)      r_leds <= w_pwm;
      else                  r_leds <= '0;
    end
  end

  assign out_leds    = r_leds;
  assign o_dbg_state = w_state;

endmodule
